// File: rtl/rob_pkg.sv
// Shared reorder-buffer definitions: entry layout, robn/pointer widths and default sizing.
// Imported by the ROB itself and by reg_station/dispatch so every block agrees on robn width.
package rob_pkg;

    localparam int ROB_ENTRIES = 16;
    localparam int ARCH_REGS   = 64;
    localparam int DISPATCH_W  = 2;
    localparam int FU_PORTS    = 3;
    localparam int RETIRE_W    = 2;

    localparam int ROB_IDX_W   = $clog2(ROB_ENTRIES);
    localparam int REG_IDX_W   = $clog2(ARCH_REGS);

    typedef logic [ROB_IDX_W-1:0] robn_t;

    // The extra MSB is the wrap bit that tells a full buffer from an empty one.
    typedef logic [ROB_IDX_W:0] ptr_t;

    typedef struct packed {
        logic                 busy;
        logic                 done;
        logic                 is_sw;
        logic [REG_IDX_W-1:0] dest_reg;
    } rob_entry_t;

    function automatic robn_t ptr_idx(input ptr_t p);
        return p[ROB_IDX_W-1:0];
    endfunction

endpackage

// File: rtl/rob_retire_select.sv
// Picks the in-order retire lanes: lane r retires head+r only when every earlier lane retires too.
// Purely combinational; works on the done bits registered before the current edge.
module rob_retire_select
    import rob_pkg::*;
#(
    parameter int ROB_ROWS    = ROB_ENTRIES,
    parameter int RETIRE_ROWS = RETIRE_W
) (
    input  robn_t                    head_idx_i,
    input  logic  [ROB_ROWS-1:0]     busy_i,
    input  logic  [ROB_ROWS-1:0]     done_i,
    output logic  [RETIRE_ROWS-1:0]  valid_o,
    output robn_t [RETIRE_ROWS-1:0]  idx_o
);

    logic chain;

    always_comb begin
        chain   = 1'b1;
        valid_o = '0;
        idx_o   = '0;
        for (int r = 0; r < RETIRE_ROWS; r++) begin
            idx_o[r]   = head_idx_i + robn_t'(r);
            chain      = chain & busy_i[idx_o[r]] & done_i[idx_o[r]];
            valid_o[r] = chain;
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// Reorder buffer: hands out robns at dispatch, collects out-of-order FU completions and
// retires up to RETIRE_ROWS entries per cycle in program order.
module reorder_buffer
    import rob_pkg::*;
#(
    parameter int ROB_ROWS    = ROB_ENTRIES,
    parameter int REG_NUM     = ARCH_REGS,
    parameter int INPUT_ROWS  = DISPATCH_W,
    parameter int ALU_NUM     = FU_PORTS,
    parameter int RETIRE_ROWS = RETIRE_W
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [INPUT_ROWS-1:0]                         alloc_valid,
    input  logic [INPUT_ROWS-1:0][$clog2(REG_NUM)-1:0]    alloc_dest_reg,
    output logic                                          alloc_ready,
    output logic [INPUT_ROWS-1:0][$clog2(ROB_ROWS)-1:0]   alloc_robn,
    input  logic [ALU_NUM-1:0]                            Comp,
    input  logic [ALU_NUM-1:0][$clog2(ROB_ROWS)-1:0]      out_robn,
    input  logic [ALU_NUM-1:0]                            is_sw,
    output logic [RETIRE_ROWS-1:0]                        retire_valid,
    output logic [RETIRE_ROWS-1:0][$clog2(ROB_ROWS)-1:0]  retire_robn,
    output logic [RETIRE_ROWS-1:0][$clog2(REG_NUM)-1:0]   retire_dest_reg,
    output logic [RETIRE_ROWS-1:0]                        retire_is_sw,
    output logic [$clog2(ROB_ROWS):0]                     rob_count,
    output logic                                          err_spurious
);

    ptr_t                                head_q, head_d;
    ptr_t                                tail_q, tail_d;
    logic [ROB_IDX_W:0]                  count_q, count_d;
    rob_entry_t                          rob_q [ROB_ROWS];
    rob_entry_t                          rob_d [ROB_ROWS];
    logic                                alloc_ready_q, alloc_ready_d;
    logic                                err_q, err_d;
    logic [RETIRE_ROWS-1:0]              ret_valid_q, ret_valid_d;
    robn_t [RETIRE_ROWS-1:0]             ret_robn_q, ret_robn_d;
    logic [RETIRE_ROWS-1:0][REG_IDX_W-1:0] ret_dest_q, ret_dest_d;
    logic [RETIRE_ROWS-1:0]              ret_sw_q, ret_sw_d;

    logic [ROB_ROWS-1:0]                 busy_vec, done_vec;
    logic [RETIRE_ROWS-1:0]              sel_valid;
    robn_t [RETIRE_ROWS-1:0]             sel_idx;
    robn_t                               head_idx;
    logic [ROB_IDX_W:0]                  alloc_cnt, alloc_add, ret_cnt;

    always_comb begin
        for (int i = 0; i < ROB_ROWS; i++) begin
            busy_vec[i] = rob_q[i].busy;
            done_vec[i] = rob_q[i].done;
        end
    end

    assign head_idx = ptr_idx(head_q);

    rob_retire_select #(
        .ROB_ROWS    (ROB_ROWS),
        .RETIRE_ROWS (RETIRE_ROWS)
    ) u_retire_select (
        .head_idx_i (head_idx),
        .busy_i     (busy_vec),
        .done_i     (done_vec),
        .valid_o    (sel_valid),
        .idx_o      (sel_idx)
    );

    // Valid lanes are compacted: each lane's robn is tail plus the number of valid lanes below it.
    always_comb begin
        alloc_cnt = '0;
        for (int l = 0; l < INPUT_ROWS; l++) begin
            alloc_robn[l] = ptr_idx(tail_q) + robn_t'(alloc_cnt);
            alloc_cnt     = alloc_cnt + ptr_t'(alloc_valid[l]);
        end
    end

    always_comb begin
        rob_d       = rob_q;
        err_d       = err_q;
        ret_cnt     = '0;
        ret_valid_d = '0;
        ret_robn_d  = '0;
        ret_dest_d  = '0;
        ret_sw_d    = '0;

        // Walk FUs from highest to lowest so the lowest port wins a duplicate robn.
        for (int k = ALU_NUM - 1; k >= 0; k--) begin
            if (Comp[k]) begin
                if (!rob_q[out_robn[k]].busy) begin
                    err_d = 1'b1;
                end else if (!rob_q[out_robn[k]].done) begin
                    rob_d[out_robn[k]].done  = 1'b1;
                    rob_d[out_robn[k]].is_sw = is_sw[k];
                end
            end
        end

        for (int r = 0; r < RETIRE_ROWS; r++) begin
            if (sel_valid[r]) begin
                ret_valid_d[r]            = 1'b1;
                ret_robn_d[r]             = sel_idx[r];
                ret_dest_d[r]             = rob_q[sel_idx[r]].dest_reg;
                ret_sw_d[r]               = rob_q[sel_idx[r]].is_sw;
                rob_d[sel_idx[r]].busy    = 1'b0;
                rob_d[sel_idx[r]].done    = 1'b0;
                rob_d[sel_idx[r]].is_sw   = 1'b0;
                ret_cnt                   = ret_cnt + ptr_t'(1);
            end
        end

        // Allocation only ever targets free slots, so it cannot collide with retire or completion.
        alloc_add = alloc_ready_q ? alloc_cnt : '0;
        if (alloc_ready_q) begin
            for (int l = 0; l < INPUT_ROWS; l++) begin
                if (alloc_valid[l]) begin
                    rob_d[alloc_robn[l]] = '{busy: 1'b1, done: 1'b0, is_sw: 1'b0,
                                             dest_reg: alloc_dest_reg[l]};
                end
            end
        end

        head_d        = head_q + ret_cnt;
        tail_d        = tail_q + alloc_add;
        count_d       = count_q + alloc_add - ret_cnt;
        alloc_ready_d = (count_d <= ptr_t'(ROB_ROWS - INPUT_ROWS));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            alloc_ready_q <= 1'b1;
            err_q         <= 1'b0;
            ret_valid_q   <= '0;
            ret_robn_q    <= '0;
            ret_dest_q    <= '0;
            ret_sw_q      <= '0;
            for (int i = 0; i < ROB_ROWS; i++) begin
                rob_q[i] <= '0;
            end
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            alloc_ready_q <= alloc_ready_d;
            err_q         <= err_d;
            ret_valid_q   <= ret_valid_d;
            ret_robn_q    <= ret_robn_d;
            ret_dest_q    <= ret_dest_d;
            ret_sw_q      <= ret_sw_d;
            rob_q         <= rob_d;
        end
    end

    assign alloc_ready     = alloc_ready_q;
    assign retire_valid    = ret_valid_q;
    assign retire_robn     = ret_robn_q;
    assign retire_dest_reg = ret_dest_q;
    assign retire_is_sw    = ret_sw_q;
    assign rob_count       = count_q;
    assign err_spurious    = err_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: a vector table for alloc/complete/retire basics, then
// hand-written sequences for reset mid-flight, fill/backpressure and head wrap-around.
module tb_reorder_buffer;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      alloc_valid;
    logic [1:0][5:0] alloc_dest_reg;
    logic            alloc_ready;
    logic [1:0][3:0] alloc_robn;
    logic [2:0]      Comp;
    logic [2:0][3:0] out_robn;
    logic [2:0]      is_sw;
    logic [1:0]      retire_valid;
    logic [1:0][3:0] retire_robn;
    logic [1:0][5:0] retire_dest_reg;
    logic [1:0]      retire_is_sw;
    logic [4:0]      rob_count;
    logic            err_spurious;

    int checkCount = 0;
    int failCount  = 0;

    reorder_buffer dut (
        .clk             (clk),
        .rst             (rst),
        .alloc_valid     (alloc_valid),
        .alloc_dest_reg  (alloc_dest_reg),
        .alloc_ready     (alloc_ready),
        .alloc_robn      (alloc_robn),
        .Comp            (Comp),
        .out_robn        (out_robn),
        .is_sw           (is_sw),
        .retire_valid    (retire_valid),
        .retire_robn     (retire_robn),
        .retire_dest_reg (retire_dest_reg),
        .retire_is_sw    (retire_is_sw),
        .rob_count       (rob_count),
        .err_spurious    (err_spurious)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] allocValid;
        logic [5:0] dest0, dest1;
        logic [2:0] comp;
        logic [3:0] robn0, robn1, robn2;
        logic [2:0] isSw;
        logic [3:0] expRobn0, expRobn1;
        logic [1:0] expRetValid;
        logic [3:0] expRetRobn0, expRetRobn1;
        logic [5:0] expRetDest0, expRetDest1;
        logic [1:0] expRetSw;
        logic [4:0] expCount;
        logic       expReady;
        logic       expErr;
        string      name;
    } vec_t;

    vec_t vecs [12];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        alloc_valid       = v.allocValid;
        alloc_dest_reg[0] = v.dest0;
        alloc_dest_reg[1] = v.dest1;
        Comp              = v.comp;
        out_robn[0]       = v.robn0;
        out_robn[1]       = v.robn1;
        out_robn[2]       = v.robn2;
        is_sw             = v.isSw;
    endtask

    task automatic clearInputs();
        alloc_valid    = '0;
        alloc_dest_reg = '0;
        Comp           = '0;
        out_robn       = '0;
        is_sw          = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int waitCycles;

        //             av     d0  d1  comp    r0 r1 r2 isSw    aR0 aR1 rv     rR0 rR1 rD0 rD1 rSw   cnt rdy err name
        vecs[0]  = '{2'b11,  5,  6, 3'b000, 0, 0, 0, 3'b000, 0,  1,  2'b00, 0,  0,  0,  0,  2'b00, 2,  1,  0, "alloc01"};
        vecs[1]  = '{2'b00,  0,  0, 3'b010, 0, 1, 0, 3'b000, 2,  2,  2'b00, 0,  0,  0,  0,  2'b00, 2,  1,  0, "compRobn1"};
        vecs[2]  = '{2'b00,  0,  0, 3'b001, 0, 0, 0, 3'b000, 2,  2,  2'b00, 0,  0,  0,  0,  2'b00, 2,  1,  0, "compRobn0"};
        vecs[3]  = '{2'b00,  0,  0, 3'b000, 0, 0, 0, 3'b000, 2,  2,  2'b11, 0,  1,  5,  6,  2'b00, 0,  1,  0, "retire01"};
        vecs[4]  = '{2'b00,  0,  0, 3'b000, 0, 0, 0, 3'b000, 2,  2,  2'b00, 0,  0,  0,  0,  2'b00, 0,  1,  0, "idleEmpty"};
        vecs[5]  = '{2'b11, 10, 11, 3'b000, 0, 0, 0, 3'b000, 2,  3,  2'b00, 0,  0,  0,  0,  2'b00, 2,  1,  0, "alloc23"};
        vecs[6]  = '{2'b11, 12, 13, 3'b000, 0, 0, 0, 3'b000, 4,  5,  2'b00, 0,  0,  0,  0,  2'b00, 4,  1,  0, "alloc45"};
        vecs[7]  = '{2'b00,  0,  0, 3'b101, 2, 0, 3, 3'b100, 6,  6,  2'b00, 0,  0,  0,  0,  2'b00, 4,  1,  0, "compStore"};
        vecs[8]  = '{2'b00,  0,  0, 3'b010, 0, 9, 0, 3'b000, 6,  6,  2'b11, 2,  3,  10, 11, 2'b10, 2,  1,  1, "retireStore"};
        vecs[9]  = '{2'b00,  0,  0, 3'b000, 0, 0, 0, 3'b000, 6,  6,  2'b00, 0,  0,  0,  0,  2'b00, 2,  1,  1, "errSticky"};
        vecs[10] = '{2'b10,  0, 20, 3'b000, 0, 0, 0, 3'b000, 6,  6,  2'b00, 0,  0,  0,  0,  2'b00, 3,  1,  1, "allocLane1"};
        vecs[11] = '{2'b11, 21, 22, 3'b000, 0, 0, 0, 3'b000, 7,  8,  2'b00, 0,  0,  0,  0,  2'b00, 5,  1,  1, "alloc78"};

        rst = 1'b1;
        clearInputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("reset.count", 32'(rob_count), 32'd0);
        checkOutput("reset.ready", 32'(alloc_ready), 32'd1);
        checkOutput("reset.retValid", 32'(retire_valid), 32'd0);
        checkOutput("reset.err", 32'(err_spurious), 32'd0);
        checkOutput("reset.allocRobn0", 32'(alloc_robn[0]), 32'd0);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("%s.allocRobn0", vecs[i].name), 32'(alloc_robn[0]), 32'(vecs[i].expRobn0));
            checkOutput($sformatf("%s.allocRobn1", vecs[i].name), 32'(alloc_robn[1]), 32'(vecs[i].expRobn1));
            @(posedge clk);
            #1;
            checkOutput($sformatf("%s.retValid", vecs[i].name), 32'(retire_valid), 32'(vecs[i].expRetValid));
            checkOutput($sformatf("%s.retRobn0", vecs[i].name), 32'(retire_robn[0]), 32'(vecs[i].expRetRobn0));
            checkOutput($sformatf("%s.retRobn1", vecs[i].name), 32'(retire_robn[1]), 32'(vecs[i].expRetRobn1));
            checkOutput($sformatf("%s.retDest0", vecs[i].name), 32'(retire_dest_reg[0]), 32'(vecs[i].expRetDest0));
            checkOutput($sformatf("%s.retDest1", vecs[i].name), 32'(retire_dest_reg[1]), 32'(vecs[i].expRetDest1));
            checkOutput($sformatf("%s.retSw", vecs[i].name), 32'(retire_is_sw), 32'(vecs[i].expRetSw));
            checkOutput($sformatf("%s.count", vecs[i].name), 32'(rob_count), 32'(vecs[i].expCount));
            checkOutput($sformatf("%s.ready", vecs[i].name), 32'(alloc_ready), 32'(vecs[i].expReady));
            checkOutput($sformatf("%s.err", vecs[i].name), 32'(err_spurious), 32'(vecs[i].expErr));
        end

        // Reset with five busy entries (4..8) while a completion is in flight.
        clearInputs();
        rst         = 1'b1;
        Comp        = 3'b001;
        out_robn[0] = 4'd4;
        tick();
        rst  = 1'b0;
        Comp = '0;
        #1;
        checkOutput("midReset.count", 32'(rob_count), 32'd0);
        checkOutput("midReset.retValid", 32'(retire_valid), 32'd0);
        checkOutput("midReset.allocRobn0", 32'(alloc_robn[0]), 32'd0);
        checkOutput("midReset.err", 32'(err_spurious), 32'd0);
        checkOutput("midReset.ready", 32'(alloc_ready), 32'd1);
        tick();
        checkOutput("midReset.noRetire", 32'(retire_valid), 32'd0);

        // Fill to 15 entries: ready must drop once fewer than two slots remain.
        for (int i = 0; i < 7; i++) begin
            alloc_valid       = 2'b11;
            alloc_dest_reg[0] = 6'(2 * i);
            alloc_dest_reg[1] = 6'(2 * i + 1);
            #1;
            checkOutput($sformatf("fill%0d.allocRobn0", i), 32'(alloc_robn[0]), 32'(2 * i));
            tick();
            checkOutput($sformatf("fill%0d.count", i), 32'(rob_count), 32'(2 * i + 2));
            checkOutput($sformatf("fill%0d.ready", i), 32'(alloc_ready), 32'd1);
        end
        alloc_valid       = 2'b01;
        alloc_dest_reg[0] = 6'd40;
        tick();
        checkOutput("fill15.count", 32'(rob_count), 32'd15);
        checkOutput("fill15.ready", 32'(alloc_ready), 32'd0);
        alloc_valid = 2'b11;
        #1;
        checkOutput("stall.allocRobn0", 32'(alloc_robn[0]), 32'd15);
        tick();
        checkOutput("stall.countHeld", 32'(rob_count), 32'd15);
        checkOutput("stall.readyHeld", 32'(alloc_ready), 32'd0);
        alloc_valid = 2'b00;
        Comp        = 3'b011;
        out_robn[0] = 4'd0;
        out_robn[1] = 4'd1;
        tick();
        Comp = '0;
        checkOutput("fullComp.retValid", 32'(retire_valid), 32'd0);
        tick();
        checkOutput("fullRetire.retValid", 32'(retire_valid), 32'd3);
        checkOutput("fullRetire.retRobn1", 32'(retire_robn[1]), 32'd1);
        checkOutput("fullRetire.retDest1", 32'(retire_dest_reg[1]), 32'd1);
        checkOutput("fullRetire.count", 32'(rob_count), 32'd13);
        checkOutput("fullRetire.ready", 32'(alloc_ready), 32'd1);

        // Wrap: robn 15 and 0 go to the tail, then drain 2..14 so head sits at 15.
        alloc_valid       = 2'b11;
        alloc_dest_reg[0] = 6'd30;
        alloc_dest_reg[1] = 6'd31;
        #1;
        checkOutput("wrapAlloc.allocRobn0", 32'(alloc_robn[0]), 32'd15);
        checkOutput("wrapAlloc.allocRobn1", 32'(alloc_robn[1]), 32'd0);
        tick();
        alloc_valid = 2'b00;
        checkOutput("wrapAlloc.count", 32'(rob_count), 32'd15);
        for (int b = 2; b <= 14; b += 3) begin
            for (int k = 0; k < 3; k++) begin
                Comp[k]     = (b + k <= 14);
                out_robn[k] = 4'(b + k);
            end
            tick();
        end
        Comp = '0;
        waitCycles = 0;
        while (rob_count != 5'd2 && waitCycles < 40) begin
            tick();
            waitCycles++;
        end
        checkOutput("wrapDrain.count", 32'(rob_count), 32'd2);
        tick();
        checkOutput("wrapDrain.idle", 32'(retire_valid), 32'd0);
        Comp        = 3'b011;
        out_robn[0] = 4'd15;
        out_robn[1] = 4'd0;
        tick();
        Comp = '0;
        tick();
        checkOutput("wrapRetire.retValid", 32'(retire_valid), 32'd3);
        checkOutput("wrapRetire.retRobn0", 32'(retire_robn[0]), 32'd15);
        checkOutput("wrapRetire.retRobn1", 32'(retire_robn[1]), 32'd0);
        checkOutput("wrapRetire.retDest0", 32'(retire_dest_reg[0]), 32'd30);
        checkOutput("wrapRetire.retDest1", 32'(retire_dest_reg[1]), 32'd31);
        checkOutput("wrapRetire.count", 32'(rob_count), 32'd0);
        checkOutput("wrapRetire.tail", 32'(alloc_robn[0]), 32'd1);
        checkOutput("wrapRetire.err", 32'(err_spurious), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
